dynpostsubdiv: RTL and testbench



---
 rtl/dynpostsubdiv_pkg.sv | 35 +++
 rtl/dynpostsubdiv_if.sv | 26 ++
 rtl/dynpostsubdiv_step.sv | 21 ++
 rtl/dynpostsubdiv.sv | 183 ++++++++++++++++++
 tb/tb_dynpostsubdiv.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dynpostsubdiv_pkg.sv
// Shared types and width helpers for the post-add/sub restoring divider.
// The top-level honours the optional macro DYNPOSTSUBDIV_DZ_SAT_EN.
package dynpostsubdiv_pkg;

    localparam logic [2:0] ENC_IDLE = 3'd0;
    localparam logic [2:0] ENC_PRE  = 3'd1;
    localparam logic [2:0] ENC_DIV  = 3'd2;
    localparam logic [2:0] ENC_FIX  = 3'd3;
    localparam logic [2:0] ENC_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ENC_IDLE,
        S_PRE  = ENC_PRE,
        S_DIV  = ENC_DIV,
        S_FIX  = ENC_FIX,
        S_DONE = ENC_DONE
    } state_e;

    // Sign bit of the saturated quotient; the remaining bits are its complement.
    localparam logic SAT_POS_SIGN = 1'b0;
    localparam logic SAT_NEG_SIGN = 1'b1;

    function automatic int dvd_width(input int sizein);
        return 2 * sizein + 2;
    endfunction

    function automatic int quo_width(input int sizein);
        return 2 * sizein + 3;
    endfunction

    function automatic int cnt_width(input int sizein);
        return $clog2(dvd_width(sizein));
    endfunction

endpackage

// File: rtl/dynpostsubdiv_if.sv
// Operand/result handshake bundle for dynpostsubdiv.
interface dynpostsubdiv_if #(
    parameter int SIZEIN = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  subadd;
    logic [2*SIZEIN:0]     p;
    logic [2*SIZEIN:0]     d;
    logic [SIZEIN-1:0]     c;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*SIZEIN+2:0]   quotient;
    logic [SIZEIN-1:0]     remainder;
    logic                  div_zero;

    modport slave (
        input  in_valid, subadd, p, d, c, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );

    modport master (
        output in_valid, subadd, p, d, c, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/dynpostsubdiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract |c| if it fits.
module dynpostsubdiv_step #(
    parameter int SIZEIN = 16
) (
    input  logic [SIZEIN-1:0] rem_i,
    input  logic              bit_i,
    input  logic [SIZEIN-1:0] div_i,
    output logic [SIZEIN-1:0] rem_o,
    output logic              qbit_o
);
    logic [SIZEIN:0] trial;
    logic [SIZEIN:0] diff;

    always_comb begin
        trial  = {rem_i, bit_i};
        diff   = trial - {1'b0, div_i};
        qbit_o = (trial >= {1'b0, div_i});
        // Either branch is below |c|, so the top bit is always zero here.
        rem_o  = qbit_o ? diff[SIZEIN-1:0] : trial[SIZEIN-1:0];
    end
endmodule

// File: rtl/dynpostsubdiv.sv
// Recovers the operand of a multiply-add: (p -/+ d) / c by sequential restoring division.
// Optional macro DYNPOSTSUBDIV_DZ_SAT_EN saturates the quotient on divide by zero.
module dynpostsubdiv
    import dynpostsubdiv_pkg::*;
#(
    parameter int SIZEIN = 16
) (
    input logic            clk,
    input logic            rst_n,
    input logic            ce,
    dynpostsubdiv_if.slave bus
);
    localparam int PW = 2 * SIZEIN + 1;
    localparam int NB = dvd_width(SIZEIN);
    localparam int QW = quo_width(SIZEIN);
    localparam int CW = cnt_width(SIZEIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [QW-1:0] QSAT_POS = {SAT_POS_SIGN, {NB{~SAT_POS_SIGN}}};
    localparam logic [QW-1:0] QSAT_NEG = {SAT_NEG_SIGN, {NB{~SAT_NEG_SIGN}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;
    logic [PW-1:0]     d_q, d_d;
    logic [SIZEIN-1:0] c_q, c_d;
    logic              subadd_q, subadd_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic              neg_c_q, neg_c_d;
    logic              dz_q, dz_d;
    logic [NB-1:0]     dvd_q, dvd_d;
    logic [SIZEIN-1:0] rem_q, rem_d;
    logic [SIZEIN-1:0] divmag_q, divmag_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [SIZEIN-1:0] remo_q, remo_d;
    logic              dzo_q, dzo_d;
    logic              ovalid_q, ovalid_d;

    logic [NB-1:0]     p_ext, d_ext, dividend, dvd_mag;
    logic [SIZEIN-1:0] c_mag;
    logic [SIZEIN-1:0] step_rem;
    logic              step_qbit;
    logic [QW-1:0]     qpos;

    assign p_ext    = {p_q[PW-1], p_q};
    assign d_ext    = {d_q[PW-1], d_q};
    assign dividend = subadd_q ? (p_ext - d_ext) : (p_ext + d_ext);
    assign dvd_mag  = dividend[NB-1] ? -dividend : dividend;
    assign c_mag    = c_q[SIZEIN-1] ? -c_q : c_q;
    assign qpos     = {1'b0, dvd_q};

    dynpostsubdiv_step #(.SIZEIN(SIZEIN)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[NB-1]),
        .div_i  (divmag_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        d_d       = d_q;
        c_d       = c_q;
        subadd_d  = subadd_q;
        neg_dvd_d = neg_dvd_q;
        neg_c_d   = neg_c_q;
        dz_d      = dz_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        divmag_d  = divmag_q;
        quo_d     = quo_q;
        remo_d    = remo_q;
        dzo_d     = dzo_q;
        ovalid_d  = ovalid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    p_d      = bus.p;
                    d_d      = bus.d;
                    c_d      = bus.c;
                    subadd_d = bus.subadd;
                    state_d  = S_PRE;
                end
            end
            S_PRE: begin
                neg_dvd_d = dividend[NB-1];
                neg_c_d   = c_q[SIZEIN-1];
                dz_d      = (c_q == '0);
                rem_d     = '0;
                cnt_d     = CNT_LAST;
                // On divide by zero the signed dividend is kept for the saturating remainder.
                if (c_q == '0) begin
                    dvd_d   = dividend;
                    state_d = S_FIX;
                end else begin
                    dvd_d    = dvd_mag;
                    divmag_d = c_mag;
                    state_d  = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[NB-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (dz_q) begin
`ifdef DYNPOSTSUBDIV_DZ_SAT_EN
                    quo_d  = neg_dvd_q ? QSAT_NEG : QSAT_POS;
                    remo_d = dvd_q[SIZEIN-1:0];
`else
                    quo_d  = '0;
                    remo_d = '0;
`endif
                end else begin
                    quo_d  = (neg_dvd_q ^ neg_c_q) ? -qpos : qpos;
                    remo_d = neg_dvd_q ? -rem_q : rem_q;
                end
                dzo_d    = dz_q;
                ovalid_d = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            d_q       <= '0;
            c_q       <= '0;
            subadd_q  <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_c_q   <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            divmag_q  <= '0;
            quo_q     <= '0;
            remo_q    <= '0;
            dzo_q     <= 1'b0;
            ovalid_q  <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            d_q       <= d_d;
            c_q       <= c_d;
            subadd_q  <= subadd_d;
            neg_dvd_q <= neg_dvd_d;
            neg_c_q   <= neg_c_d;
            dz_q      <= dz_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            divmag_q  <= divmag_d;
            quo_q     <= quo_d;
            remo_q    <= remo_d;
            dzo_q     <= dzo_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = ovalid_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = remo_q;
    assign bus.div_zero  = dzo_q;

endmodule

// File: tb/tb_dynpostsubdiv.sv
// Randomised self-checking bench for dynpostsubdiv against a plain-arithmetic model.
module tb_dynpostsubdiv;
    localparam int SIZEIN = 16;
    localparam int PW = 2 * SIZEIN + 1;
    localparam int NB = 2 * SIZEIN + 2;
    localparam int QW = 2 * SIZEIN + 3;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    int checks = 0;
    int errors = 0;

    dynpostsubdiv_if #(.SIZEIN(SIZEIN)) bus ();

    dynpostsubdiv #(.SIZEIN(SIZEIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: signed integer division, truncating toward zero.
    task automatic model(input logic sa, input logic [PW-1:0] p, input logic [PW-1:0] d,
                         input logic [SIZEIN-1:0] c, output logic [QW-1:0] q,
                         output logic [SIZEIN-1:0] r, output logic dz);
        longint pv, dv, cv, dvd;
        pv  = longint'($signed(p));
        dv  = longint'($signed(d));
        cv  = longint'($signed(c));
        dvd = sa ? (pv - dv) : (pv + dv);
        if (cv == 0) begin
            dz = 1'b1;
`ifdef DYNPOSTSUBDIV_DZ_SAT_EN
            q = (dvd >= 0) ? QW'((longint'(1) <<< (QW - 1)) - 1) : QW'(longint'(1) <<< (QW - 1));
            r = SIZEIN'(dvd);
`else
            q = '0;
            r = '0;
`endif
        end else begin
            dz = 1'b0;
            q  = QW'(dvd / cv);
            r  = SIZEIN'(dvd % cv);
        end
    endtask

    task automatic issue(input logic sa, input logic [PW-1:0] p, input logic [PW-1:0] d,
                         input logic [SIZEIN-1:0] c);
        bus.in_valid = 1'b1;
        bus.subadd   = sa;
        bus.p        = p;
        bus.d        = d;
        bus.c        = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0h expected 0", bus.quotient); end
        checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %0h expected 0", bus.remainder); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
        rst_n = 1'b1;
        ce    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic              sa_t [5];
        logic [PW-1:0]     p_t  [5];
        logic [PW-1:0]     d_t  [5];
        logic [SIZEIN-1:0] c_t  [5];
        logic [QW-1:0]     eq;
        logic [SIZEIN-1:0] er;
        logic              edz;
        int                n;
        sa_t[0] = 1'b0; p_t[0] = PW'(1000);  d_t[0] = PW'(23);             c_t[0] = 16'd7;
        sa_t[1] = 1'b1; p_t[1] = -PW'(1000); d_t[1] = PW'(23);             c_t[1] = 16'd7;
        sa_t[2] = 1'b0; p_t[2] = 33'h1_0000_0000; d_t[2] = 33'h1_0000_0000; c_t[2] = 16'hFFFF;
        sa_t[3] = 1'b0; p_t[3] = PW'(500);   d_t[3] = '0;                  c_t[3] = '0;
        sa_t[4] = 1'b1; p_t[4] = PW'(3);     d_t[4] = PW'(10);             c_t[4] = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            model(sa_t[i], p_t[i], d_t[i], c_t[i], eq, er, edz);
            issue(sa_t[i], p_t[i], d_t[i], c_t[i]);
            wait_valid(n);
            checks++; if (n != (edz ? 2 : NB + 2)) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, n, edz ? 2 : NB + 2); end
            checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL dir%0d_quotient: got %0d expected %0d", i, $signed(bus.quotient), $signed(eq)); end
            checks++; if (bus.remainder !== er) begin errors++; $display("FAIL dir%0d_remainder: got %0d expected %0d", i, $signed(bus.remainder), $signed(er)); end
            checks++; if (bus.div_zero !== edz) begin errors++; $display("FAIL dir%0d_div_zero: got %b expected %b", i, bus.div_zero, edz); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_release: got valid=%b ready=%b expected valid=0 ready=1", i, bus.out_valid, bus.in_ready); end
        end
        // Spot-check the model itself on the headline vector.
        model(1'b0, PW'(1000), PW'(23), 16'd7, eq, er, edz);
        checks++; if (eq !== QW'(146) || er !== 16'd1) begin errors++; $display("FAIL model_1023_by_7: got %0d r %0d expected 146 r 1", eq, er); end
    endtask

    task automatic test_random;
        logic              sa;
        logic [PW-1:0]     p, d;
        logic [SIZEIN-1:0] c;
        logic [QW-1:0]     eq;
        logic [SIZEIN-1:0] er;
        logic              edz;
        int                n, sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(9, 0));
            sa  = 1'($urandom);
            p   = {1'($urandom), $urandom};
            d   = {1'($urandom), $urandom};
            c   = 16'($urandom);
            case (sel)
                0: c = '0;
                1: c = '1;
                2: c = 16'h8000;
                3: begin p = 33'h1_0000_0000; d = 33'h0_FFFF_FFFF; end
                4: c = 16'($urandom_range(9, 1));
                default: ;
            endcase
            model(sa, p, d, c, eq, er, edz);
            issue(sa, p, d, c);
            wait_valid(n);
            checks++; if (n != (edz ? 2 : NB + 2)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, n, edz ? 2 : NB + 2); end
            checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL rnd%0d_quotient: got %0d expected %0d", i, $signed(bus.quotient), $signed(eq)); end
            checks++; if (bus.remainder !== er) begin errors++; $display("FAIL rnd%0d_remainder: got %0d expected %0d", i, $signed(bus.remainder), $signed(er)); end
            checks++; if (bus.div_zero !== edz) begin errors++; $display("FAIL rnd%0d_div_zero: got %b expected %b", i, bus.div_zero, edz); end
            repeat ($urandom_range(2, 0)) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_stall;
        logic [QW-1:0]     eq, q0;
        logic [SIZEIN-1:0] er, r0;
        logic              edz;
        int                n, bad;
        model(1'b0, PW'(1000), PW'(23), 16'd7, eq, er, edz);
        issue(1'b0, PW'(1000), PW'(23), 16'd7);
        // Busy-time operands must be ignored.
        bus.in_valid = 1'b1;
        bus.p        = PW'(77777);
        bus.c        = 16'd3;
        repeat (5) @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        wait_valid(n);
        checks++; if (5 + 3 + n != NB + 5) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", 8 + n, NB + 5); end
        q0  = bus.quotient;
        r0  = bus.remainder;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== q0 || bus.remainder !== r0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
        checks++; if (q0 !== eq || r0 !== er) begin errors++; $display("FAIL stall_result: got %0d r %0d expected %0d r %0d", $signed(q0), $signed(r0), $signed(eq), $signed(er)); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got ready=%b valid=%b expected ready=1 valid=0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [QW-1:0]     eq;
        logic [SIZEIN-1:0] er;
        logic              edz;
        int                n;
        issue(1'b1, 33'h0_1234_5678, 33'h1_8765_4321, 16'h00A5);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_state: got ready=%b valid=%b expected ready=1 valid=0", bus.in_ready, bus.out_valid); end
        model(1'b0, PW'(84), '0, -16'sd5, eq, er, edz);
        issue(1'b0, PW'(84), '0, -16'sd5);
        wait_valid(n);
        checks++; if (n != NB + 2) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", n, NB + 2); end
        checks++; if (bus.quotient !== eq || bus.quotient !== -QW'(16)) begin errors++; $display("FAIL midreset_quotient: got %0d expected -16", $signed(bus.quotient)); end
        checks++; if (bus.remainder !== er || bus.remainder !== 16'd4) begin errors++; $display("FAIL midreset_remainder: got %0d expected 4", $signed(bus.remainder)); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0]     pb;
        logic [SIZEIN-1:0] cb;
        logic [QW-1:0]     qa, qb;
        logic [SIZEIN-1:0] ra, rb;
        logic              dza, dzb;
        int                n;
        pb = {1'($urandom), $urandom};
        cb = 16'($urandom_range(60000, 1));
        model(1'b1, PW'(-12345), PW'(678), 16'd99, qa, ra, dza);
        model(1'b0, pb, PW'(5), cb, qb, rb, dzb);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.subadd    = 1'b1;
        bus.p         = PW'(-12345);
        bus.d         = PW'(678);
        bus.c         = 16'd99;
        @(negedge clk);
        bus.subadd = 1'b0;
        bus.p      = pb;
        bus.d      = PW'(5);
        bus.c      = cb;
        wait_valid(n);
        checks++; if (n != NB + 2) begin errors++; $display("FAIL b2b_a_latency: got %0d expected %0d", n, NB + 2); end
        checks++; if (bus.quotient !== qa || bus.remainder !== ra) begin errors++; $display("FAIL b2b_a_result: got %0d r %0d expected %0d r %0d", $signed(bus.quotient), $signed(bus.remainder), $signed(qa), $signed(ra)); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_turnaround: got ready=%b valid=%b expected ready=1 valid=0", bus.in_ready, bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: got ready=%b expected 0", bus.in_ready); end
        wait_valid(n);
        checks++; if (n != NB + 2) begin errors++; $display("FAIL b2b_b_latency: got %0d expected %0d", n, NB + 2); end
        checks++; if (bus.quotient !== qb || bus.remainder !== rb) begin errors++; $display("FAIL b2b_b_result: got %0d r %0d expected %0d r %0d", $signed(bus.quotient), $signed(bus.remainder), $signed(qb), $signed(rb)); end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.subadd    = 1'b0;
        bus.p         = '0;
        bus.d         = '0;
        bus.c         = '0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
